sdr_rd_stream: RTL and testbench

Read-side streaming client for `sdr_top`, the counterpart of the write-data path that feeds `sdr_wdata_in`/`sdr_wdata_wr`. On a start pulse it issues burst read requests to `sdr_top` (`sdr_rd_req`/`sdr_raddr`), collects returned words from `sdr_rdata_out`/`sdr_rd_vld` into a local FIFO, and presents them downstream on a valid/ready stream. It sits between `sdr_top` and any consumer, such as a DMA engine or a readback checker.

---
 rtl/sdr_rd_pkg.sv | 15 +
 rtl/sdr_rd_fifo.sv | 66 ++++++
 rtl/sdr_rd_stream.sv | 162 ++++++++++++++++
 tb/tb_sdr_rd_stream.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_rd_pkg.sv
// Shared types and widths for the SDRAM read-stream client.
package sdr_rd_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } sdr_rd_state_t;

endpackage

// File: rtl/sdr_rd_fifo.sv
// First-word-fall-through FIFO: the head word is always visible on dout_o,
// and the count and the full/empty flags come straight from registers.
module sdr_rd_fifo #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 16,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   // A pop frees a slot in the same cycle, so push-while-full is fine with a pop.
   assign do_pop  = pop_i && !empty_q;
   assign do_push = push_i && (!full_q || do_pop);

   // Occupancy next state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + CW'(1);
      else if (!do_push && do_pop)
         count_d = count_q - CW'(1);
   end

   // Storage, pointers and registered flags; pointers wrap since DEPTH is 2^n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/sdr_rd_stream.sv
// Read-side streaming client: issues burst reads to sdr_top, buffers the
// returned words and hands them downstream on a valid/ready stream.
module sdr_rd_stream
   import sdr_rd_pkg::*;
#(
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] rd_base_addr,
   input  logic [LEN_W-1:0]  rd_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              sdr_rd_req,
   output logic [ADDR_W-1:0] sdr_raddr,
   input  logic [DATA_W-1:0] sdr_rdata_out,
   input  logic              sdr_rd_vld,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   input  logic              dout_rdy
);

   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int CNW = CW + 1;
   localparam int BW  = $clog2(BURST_LEN + 1);

   sdr_rd_state_t     state_q;
   logic [ADDR_W-1:0] addr_q, raddr_q, next_addr;
   logic [LEN_W-1:0]  req_left_q, out_left_q, req_left_nxt;
   logic [BW-1:0]     beat_q;
   logic              busy_q, done_q, err_q, req_q;

   logic              in_wait, push, push_ok, pop, last_beat, space_ok;
   logic [CNW-1:0]    cnt_nxt;
   logic [CW-1:0]     fifo_cnt;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_dout;

   sdr_rd_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (sdr_rdata_out),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Beats past the requested length (tail of the last burst) are not pushed.
   assign in_wait      = (state_q == WAIT);
   assign push         = in_wait && sdr_rd_vld && (req_left_q != '0);
   assign pop          = !fifo_empty && dout_rdy;
   assign push_ok      = push && (!fifo_full || pop);
   assign last_beat    = in_wait && sdr_rd_vld && (beat_q == BW'(BURST_LEN - 1));
   assign req_left_nxt = push ? req_left_q - LEN_W'(1) : req_left_q;
   assign next_addr    = addr_q + ADDR_W'(BURST_LEN);

   // Space is judged on the occupancy after this edge, so a request decided
   // now is backed by room for a whole burst when its beats arrive.
   assign cnt_nxt  = CNW'(fifo_cnt) + CNW'(push_ok) - CNW'(pop);
   assign space_ok = (cnt_nxt <= CNW'(FIFO_DEPTH - BURST_LEN));

   // Control FSM; req_q high while in REQ means the request is on the bus now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         raddr_q    <= '0;
         req_left_q <= '0;
         out_left_q <= '0;
         beat_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         req_q  <= 1'b0;
         done_q <= 1'b0;
         if (pop && (out_left_q != '0))
            out_left_q <= out_left_q - LEN_W'(1);

         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q     <= rd_base_addr;
                  req_left_q <= rd_len;
                  out_left_q <= rd_len;
                  err_q      <= 1'b0;
                  if (rd_len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= REQ;
                     busy_q  <= 1'b1;
                     if (space_ok) begin
                        req_q   <= 1'b1;
                        raddr_q <= rd_base_addr;
                     end
                  end
               end
            end
            REQ: begin
               if (req_q) begin
                  state_q <= WAIT;
                  beat_q  <= '0;
               end else if (space_ok) begin
                  req_q   <= 1'b1;
                  raddr_q <= addr_q;
               end
            end
            WAIT: begin
               if (sdr_rd_vld) begin
                  req_left_q <= req_left_nxt;
                  if (last_beat) begin
                     beat_q <= '0;
                     addr_q <= next_addr;
                     if (req_left_nxt != '0) begin
                        state_q <= REQ;
                        if (space_ok) begin
                           req_q   <= 1'b1;
                           raddr_q <= next_addr;
                        end
                     end else begin
                        state_q <= FLUSH;
                     end
                  end else begin
                     beat_q <= beat_q + BW'(1);
                  end
               end
            end
            FLUSH: begin
               if (out_left_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Stray beats and overflow drops are sticky errors (win over a clear).
         if ((sdr_rd_vld && !in_wait) || (push && !push_ok))
            err_q <= 1'b1;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign sdr_rd_req = req_q;
   assign sdr_raddr  = raddr_q;
   assign dout       = fifo_dout;
   assign dout_vld   = !fifo_empty;

endmodule

// File: tb/tb_sdr_rd_stream.sv
// Bench for sdr_rd_stream: an SDRAM model returns value = address, and a
// scoreboard holds the word/request sequences each transfer must produce.
module tb_sdr_rd_stream;

   localparam int BL = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] rd_base_addr = '0;
   logic [11:0] rd_len = '0;
   logic        busy, done, err, sdr_rd_req;
   logic [31:0] sdr_raddr;
   logic [15:0] sdr_rdata_out = '0;
   logic        sdr_rd_vld = 1'b0;
   logic [15:0] dout;
   logic        dout_vld;
   logic        dout_rdy = 1'b1;

   always #5 clk = ~clk;

   sdr_rd_stream #(.BURST_LEN(BL), .FIFO_DEPTH(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .rd_base_addr  (rd_base_addr),
      .rd_len        (rd_len),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .sdr_rd_req    (sdr_rd_req),
      .sdr_raddr     (sdr_raddr),
      .sdr_rdata_out (sdr_rdata_out),
      .sdr_rd_vld    (sdr_rd_vld),
      .dout          (dout),
      .dout_vld      (dout_vld),
      .dout_rdy      (dout_rdy)
   );

   int          checks = 0, errors = 0;
   logic [15:0] exp_q[$];
   logic [31:0] exp_req[$];
   int          nreq = 0, ndone = 0, nword = 0;
   int          s_req, s_done, s_word;
   logic [31:0] last_raddr = '0;
   bit          inject = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // SDRAM: one idle cycle after a request, then BL back-to-back beats.
   initial begin : sdram
      bit          act;
      int          lat, bidx;
      logic [31:0] baddr;
      act = 1'b0; lat = 0; bidx = 0; baddr = '0;
      forever begin
         @(negedge clk);
         sdr_rd_vld = 1'b0;
         if (inject) begin
            sdr_rd_vld    = 1'b1;
            sdr_rdata_out = 16'hDEAD;
            inject        = 1'b0;
         end else if (act) begin
            if (lat > 0) lat--;
            else begin
               sdr_rd_vld    = 1'b1;
               sdr_rdata_out = 16'(baddr + 32'(bidx));
               bidx++;
               if (bidx == BL) act = 1'b0;
            end
         end
         if (rst_n && sdr_rd_req) begin
            chk("one_outstanding", 32'(act), 0);
            nreq++;
            last_raddr = sdr_raddr;
            if (exp_req.size() == 0) begin
               checks++; errors++;
               $display("FAIL req_unexpected: got request at %0h, none expected", sdr_raddr);
            end else chk("req_addr", sdr_raddr, exp_req.pop_front());
            act = 1'b1; baddr = sdr_raddr; bidx = 0; lat = 1;
         end
      end
   end

   // Per-cycle compare: stream order, hold-under-backpressure, done/busy exclusion.
   initial begin : cmp
      logic        hold;
      logic [15:0] hold_d;
      hold = 1'b0; hold_d = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) hold = 1'b0;
         else begin
            if (hold) begin
               chk("hold_vld", 32'(dout_vld), 1);
               chk("hold_data", 32'(dout), 32'(hold_d));
            end
            if (dout_vld && dout_rdy) begin
               nword++;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL extra_word: got %0h, no word expected", dout);
               end else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
            if (done) begin
               ndone++;
               chk("done_not_busy", 32'(busy), 0);
            end
            hold   = dout_vld && !dout_rdy;
            hold_d = dout;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Queue the expected words/requests, then pulse start for one cycle.
   task automatic launch(input logic [31:0] base, input int len);
      s_req = nreq; s_done = ndone; s_word = nword;
      for (int i = 0; i < len; i++) exp_q.push_back(16'(base + 32'(i)));
      for (int k = 0; k < (len + BL - 1) / BL; k++) exp_req.push_back(base + 32'(k * BL));
      start = 1'b1; rd_base_addr = base; rd_len = 12'(len);
      tick(1);
      start = 1'b0;
   endtask

   task automatic finish_xfer(input string nm, input int len);
      int t;
      t = 0;
      while (ndone == s_done && t < 5000) begin tick(1); t++; end
      if (t >= 5000) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got no done within 5000 cycles, required one", nm);
      end
      tick(3);
      chk({nm, "_reqs"}, 32'(nreq - s_req), 32'((len + BL - 1) / BL));
      chk({nm, "_words"}, 32'(nword - s_word), 32'(len));
      chk({nm, "_dones"}, 32'(ndone - s_done), 1);
      chk({nm, "_left"}, 32'(exp_q.size() + exp_req.size()), 0);
      chk({nm, "_err"}, 32'(err), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
   endtask

   initial begin : main
      int w;
      tick(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_req", 32'(sdr_rd_req), 0);
      chk("rst_vld", 32'(dout_vld), 0);
      chk("rst_raddr", sdr_raddr, 0);
      chk("rst_dout", 32'(dout), 0);
      rst_n = 1'b1;
      tick(2);

      // basic: two bursts at 0 and 8, request visible the cycle after start
      launch(32'h0, 16);
      chk("basic_first_req", 32'(sdr_rd_req), 1);
      chk("basic_first_raddr", sdr_raddr, 32'h0);
      chk("basic_busy", 32'(busy), 1);
      finish_xfer("basic", 16);
      chk("basic_nreq_lit", 32'(nreq - s_req), 2);
      chk("basic_last_raddr", last_raddr, 32'h8);

      // zero length: done next cycle, never busy, no request
      launch(32'h40, 0);
      chk("len0_done", 32'(done), 1);
      chk("len0_busy", 32'(busy), 0);
      chk("len0_req", 32'(sdr_rd_req), 0);
      tick(1);
      chk("len0_done_pulse", 32'(done), 0);
      tick(2);
      chk("len0_dones", 32'(ndone - s_done), 1);
      chk("len0_reqs", 32'(nreq - s_req), 0);

      // partial last burst: 13 words, 3 surplus beats dropped
      launch(32'h1230, 13);
      finish_xfer("len13", 13);
      chk("len13_last_raddr", last_raddr, 32'h1238);

      // address wrap across 2^32
      launch(32'hFFFF_FFF8, 16);
      finish_xfer("wrap", 16);
      chk("wrap_last_raddr", last_raddr, 32'h0);

      // long transfer with partial final burst
      launch(32'h0, 1000);
      finish_xfer("len1000", 1000);
      chk("len1000_nreq_lit", 32'(nreq - s_req), 125);
      chk("len1000_last_raddr", last_raddr, 32'd992);

      // backpressure: FIFO fills after 2 bursts, requests stall
      dout_rdy = 1'b0;
      launch(32'h2000, 40);
      tick(60);
      chk("bp_reqs_stalled", 32'(nreq - s_req), 2);
      chk("bp_vld", 32'(dout_vld), 1);
      chk("bp_head", 32'(dout), 32'h2000);
      dout_rdy = 1'b1;
      finish_xfer("bp", 40);

      // start while busy is ignored
      launch(32'h300, 24);
      tick(5);
      start = 1'b1; rd_base_addr = 32'h900; rd_len = 12'd5;
      tick(1);
      start = 1'b0;
      finish_xfer("busy_start", 24);
      chk("busy_start_last_raddr", last_raddr, 32'h310);

      // stray beat in IDLE sets err; next start clears it
      inject = 1'b1;
      tick(4);
      chk("inj_err", 32'(err), 1);
      chk("inj_vld", 32'(dout_vld), 0);
      launch(32'h50, 8);
      chk("inj_err_cleared", 32'(err), 0);
      finish_xfer("inj", 8);

      // reset in the middle of a burst
      launch(32'h600, 32);
      w = 0;
      while (nword - s_word < 2 && w < 200) begin tick(1); w++; end
      if (w >= 200) begin
         checks++; errors++;
         $display("FAIL rst_mid_timeout: got %0d words, required 2", nword - s_word);
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_err", 32'(err), 0);
      chk("mid_rst_req", 32'(sdr_rd_req), 0);
      chk("mid_rst_vld", 32'(dout_vld), 0);
      chk("mid_rst_raddr", sdr_raddr, 0);
      chk("mid_rst_dout", 32'(dout), 0);
      exp_q.delete();
      exp_req.delete();
      tick(1);
      rst_n = 1'b1;
      w = nword;
      tick(12);
      chk("late_beats_err", 32'(err), 1);
      chk("late_beats_vld", 32'(dout_vld), 0);
      chk("late_beats_busy", 32'(busy), 0);
      chk("late_beats_words", 32'(nword - w), 0);
      launch(32'h700, 8);
      chk("post_rst_err_cleared", 32'(err), 0);
      finish_xfer("post_rst", 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation still running at 900000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
